// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: credit bookkeeping plus the START/SELECT/HELP/PLAY/RESULT
// screen machine that drives the play logic and the per-screen image mux.
module game_flow_ctrl #(
    parameter int TICKET_COST = 10,
    parameter int COIN_VALUE  = 5,
    parameter int MONEY_MAX   = 99,
    parameter int TIME_LIMIT  = 60,
    parameter int REWARD      = 20,
    parameter int RESULT_SECS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [8:0] last_change,
    input  logic       coin,
    input  logic       sec_tick,
    input  logic       game_done,
    input  logic       game_win,
    output logic [2:0] state,
    output logic [2:0] level,
    output logic       ticket,
    output logic [6:0] money,
    output logic [6:0] time_left,
    output logic       play_start,
    output logic       err_no_money,
    output logic       won
);

    localparam logic [8:0] KEY_1     = 9'h016;
    localparam logic [8:0] KEY_2     = 9'h01E;
    localparam logic [8:0] KEY_3     = 9'h026;
    localparam logic [8:0] KEY_QMARK = 9'h04A;
    localparam logic [8:0] KEY_ENTER = 9'h05A;
    localparam logic [8:0] KEY_ESC   = 9'h076;

    typedef enum logic [2:0] {
        ST_START  = 3'd0,
        ST_SELECT = 3'd1,
        ST_HELP   = 3'd2,
        ST_PLAY   = 3'd3,
        ST_RESULT = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] level_q, level_d;
    logic [2:0] sel_level_q, sel_level_d;
    logic       ticket_q, ticket_d;
    logic [6:0] money_q, money_d;
    logic [6:0] time_left_q, time_left_d;
    logic       play_start_q, play_start_d;
    logic       err_no_money_q, err_no_money_d;
    logic       won_q, won_d;
    logic [3:0] res_cnt_q, res_cnt_d;

    logic       deduct_s, reward_s;
    logic       is_k1_s, is_k2_s, is_k3_s, is_qmark_s, is_enter_s, is_esc_s;
    logic [8:0] money_sum_s;

    // Clamp a widened credit sum to the ceiling; credit never wraps.
    function automatic logic [6:0] sat_money(input logic [8:0] v);
        if (v > 9'(MONEY_MAX)) begin
            sat_money = 7'(MONEY_MAX);
        end else begin
            sat_money = v[6:0];
        end
    endfunction

    // Key decode.
    always_comb begin
        is_k1_s    = key_valid && (last_change == KEY_1);
        is_k2_s    = key_valid && (last_change == KEY_2);
        is_k3_s    = key_valid && (last_change == KEY_3);
        is_qmark_s = key_valid && (last_change == KEY_QMARK);
        is_enter_s = key_valid && (last_change == KEY_ENTER);
        is_esc_s   = key_valid && (last_change == KEY_ESC);
    end

    // Next-state, registered-output and credit computation.
    always_comb begin
        state_d        = state_q;
        level_d        = level_q;
        sel_level_d    = sel_level_q;
        ticket_d       = ticket_q;
        time_left_d    = time_left_q;
        won_d          = won_q;
        res_cnt_d      = res_cnt_q;
        play_start_d   = 1'b0;
        err_no_money_d = 1'b0;
        deduct_s       = 1'b0;
        reward_s       = 1'b0;

        case (state_q)
            ST_START: begin
                if (is_enter_s) begin
                    state_d     = ST_SELECT;
                    sel_level_d = 3'd0;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_SELECT: begin
                if (is_k1_s) begin
                    sel_level_d = 3'd1;
                end else if (is_k2_s) begin
                    sel_level_d = 3'd2;
                end else if (is_k3_s) begin
                    sel_level_d = 3'd3;
                end else if (is_qmark_s) begin
                    state_d = ST_HELP;
                end else if (is_esc_s) begin
                    state_d     = ST_START;
                    sel_level_d = 3'd0;
                end else if (is_enter_s && (sel_level_q != 3'd0)) begin
                    // Affordability is judged on credit before any same-cycle coin.
                    if (money_q >= 7'(TICKET_COST)) begin
                        deduct_s     = 1'b1;
                        level_d      = sel_level_q;
                        ticket_d     = 1'b1;
                        time_left_d  = 7'(TIME_LIMIT);
                        play_start_d = 1'b1;
                        state_d      = ST_PLAY;
                    end else begin
                        err_no_money_d = 1'b1;
                    end
                end else begin
                    state_d = ST_SELECT;
                end
            end
            ST_HELP: begin
                if (key_valid) begin
                    state_d = ST_SELECT;
                end else begin
                    state_d = ST_HELP;
                end
            end
            ST_PLAY: begin
                if (sec_tick && (time_left_q != 7'd0)) begin
                    time_left_d = time_left_q - 7'd1;
                end else begin
                    time_left_d = time_left_q;
                end
                if (game_done) begin
                    state_d   = ST_RESULT;
                    won_d     = game_win;
                    reward_s  = game_win;
                    ticket_d  = 1'b0;
                    res_cnt_d = 4'd0;
                end else if (is_esc_s || (sec_tick && (time_left_q == 7'd1))) begin
                    state_d   = ST_RESULT;
                    won_d     = 1'b0;
                    ticket_d  = 1'b0;
                    res_cnt_d = 4'd0;
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_RESULT: begin
                if (is_enter_s || (sec_tick && (res_cnt_q == 4'(RESULT_SECS - 1)))) begin
                    state_d     = ST_START;
                    level_d     = 3'd0;
                    sel_level_d = 3'd0;
                    won_d       = 1'b0;
                    res_cnt_d   = 4'd0;
                end else if (sec_tick) begin
                    res_cnt_d = res_cnt_q + 4'd1;
                end else begin
                    res_cnt_d = res_cnt_q;
                end
            end
            default: begin
                state_d = ST_START;
            end
        endcase

        // Deduct only happens when credit covers the ticket, so the sum cannot underflow.
        money_sum_s = {2'b00, money_q}
                    + (coin     ? 9'(COIN_VALUE)  : 9'd0)
                    + (reward_s ? 9'(REWARD)      : 9'd0)
                    - (deduct_s ? 9'(TICKET_COST) : 9'd0);
        money_d = sat_money(money_sum_s);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_START;
            level_q        <= 3'd0;
            sel_level_q    <= 3'd0;
            ticket_q       <= 1'b0;
            money_q        <= 7'd0;
            time_left_q    <= 7'd0;
            play_start_q   <= 1'b0;
            err_no_money_q <= 1'b0;
            won_q          <= 1'b0;
            res_cnt_q      <= 4'd0;
        end else begin
            state_q        <= state_d;
            level_q        <= level_d;
            sel_level_q    <= sel_level_d;
            ticket_q       <= ticket_d;
            money_q        <= money_d;
            time_left_q    <= time_left_d;
            play_start_q   <= play_start_d;
            err_no_money_q <= err_no_money_d;
            won_q          <= won_d;
            res_cnt_q      <= res_cnt_d;
        end
    end

    assign state        = state_q;
    assign level        = level_q;
    assign ticket       = ticket_q;
    assign money        = money_q;
    assign time_left    = time_left_q;
    assign play_start   = play_start_q;
    assign err_no_money = err_no_money_q;
    assign won          = won_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed self-checking bench for game_flow_ctrl with default parameters
// (cost 10, coin 5, max 99, 60 s, reward 20, result 5 ticks).
module tb_game_flow_ctrl;

    localparam logic [8:0] KEY_1     = 9'h016;
    localparam logic [8:0] KEY_2     = 9'h01E;
    localparam logic [8:0] KEY_3     = 9'h026;
    localparam logic [8:0] KEY_QMARK = 9'h04A;
    localparam logic [8:0] KEY_ENTER = 9'h05A;
    localparam logic [8:0] KEY_ESC   = 9'h076;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_valid = 1'b0;
    logic [8:0] last_change = 9'h000;
    logic       coin = 1'b0;
    logic       sec_tick = 1'b0;
    logic       game_done = 1'b0;
    logic       game_win = 1'b0;
    logic [2:0] state;
    logic [2:0] level;
    logic       ticket;
    logic [6:0] money;
    logic [6:0] time_left;
    logic       play_start;
    logic       err_no_money;
    logic       won;

    int n_cmp = 0;
    int n_err = 0;

    game_flow_ctrl dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .last_change(last_change),
        .coin(coin), .sec_tick(sec_tick), .game_done(game_done), .game_win(game_win),
        .state(state), .level(level), .ticket(ticket), .money(money),
        .time_left(time_left), .play_start(play_start), .err_no_money(err_no_money),
        .won(won)
    );

    always #5 clk = ~clk;

    // One clock with the given pulses; outputs are stable 1 ns after the edge.
    task automatic cyc(input logic kv, input logic [8:0] code, input logic c,
                       input logic t, input logic gd, input logic gw);
        key_valid = kv; last_change = code; coin = c;
        sec_tick = t; game_done = gd; game_win = gw;
        @(posedge clk); #1;
        key_valid = 1'b0; coin = 1'b0; sec_tick = 1'b0;
        game_done = 1'b0; game_win = 1'b0;
    endtask

    task automatic key(input logic [8:0] code);
        cyc(1'b1, code, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic coins(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({state, level, ticket, money, time_left, play_start, err_no_money, won} !== 23'd0) begin
            n_err++;
            $display("FAIL reset_outputs got state=%0d level=%0d ticket=%0d money=%0d time=%0d ps=%0d err=%0d won=%0d want all 0",
                     state, level, ticket, money, time_left, play_start, err_no_money, won);
        end
        cyc(1'b0, 9'h000, 1'b0, 1'b1, 1'b1, 1'b1);
        n_cmp++;
        if ({state, won} !== 4'd0) begin
            n_err++; $display("FAIL done_outside_play state=%0d won=%0d want 0 0", state, won);
        end
    endtask

    task automatic test_start_game();
        coins(2);
        n_cmp++;
        if (money !== 7'd10) begin n_err++; $display("FAIL two_coins money=%0d want 10", money); end
        key(KEY_ENTER);
        n_cmp++;
        if (state !== 3'd1) begin n_err++; $display("FAIL start_to_select state=%0d want 1", state); end
        key(KEY_2);
        key(KEY_ENTER);
        n_cmp++;
        if ({state, level, ticket, money, time_left, play_start} !== {3'd3, 3'd2, 1'b1, 7'd0, 7'd60, 1'b1}) begin
            n_err++;
            $display("FAIL enter_play state=%0d level=%0d ticket=%0d money=%0d time=%0d ps=%0d want 3 2 1 0 60 1",
                     state, level, ticket, money, time_left, play_start);
        end
        cyc(1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (play_start !== 1'b0) begin n_err++; $display("FAIL play_start_pulse got %0d want 0", play_start); end
        key(KEY_ESC);
        n_cmp++;
        if ({state, won, ticket} !== {3'd4, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL esc_result state=%0d won=%0d ticket=%0d want 4 0 0", state, won, ticket);
        end
        key(KEY_ENTER);
        n_cmp++;
        if ({state, level} !== {3'd0, 3'd0}) begin
            n_err++; $display("FAIL result_enter state=%0d level=%0d want 0 0", state, level);
        end
    endtask

    task automatic test_no_money();
        do_reset();
        coins(1);
        key(KEY_ENTER);
        key(KEY_ENTER);
        n_cmp++;
        if ({state, err_no_money} !== {3'd1, 1'b0}) begin
            n_err++; $display("FAIL enter_no_level state=%0d err=%0d want 1 0", state, err_no_money);
        end
        key(KEY_1);
        key(KEY_ENTER);
        n_cmp++;
        if ({state, err_no_money, money} !== {3'd1, 1'b1, 7'd5}) begin
            n_err++; $display("FAIL reject_start state=%0d err=%0d money=%0d want 1 1 5", state, err_no_money, money);
        end
        cyc(1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (err_no_money !== 1'b0) begin n_err++; $display("FAIL err_pulse got %0d want 0", err_no_money); end
        cyc(1'b1, KEY_ENTER, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({state, err_no_money, money} !== {3'd1, 1'b1, 7'd10}) begin
            n_err++; $display("FAIL reject_with_coin state=%0d err=%0d money=%0d want 1 1 10", state, err_no_money, money);
        end
    endtask

    task automatic test_timeout();
        key(KEY_ENTER);
        ticks(57);
        n_cmp++;
        if ({state, level, time_left} !== {3'd3, 3'd1, 7'd3}) begin
            n_err++; $display("FAIL countdown state=%0d level=%0d time=%0d want 3 1 3", state, level, time_left);
        end
        ticks(2);
        n_cmp++;
        if ({state, time_left} !== {3'd3, 7'd1}) begin
            n_err++; $display("FAIL last_second state=%0d time=%0d want 3 1", state, time_left);
        end
        ticks(1);
        n_cmp++;
        if ({state, time_left, won, ticket} !== {3'd4, 7'd0, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL timeout state=%0d time=%0d won=%0d ticket=%0d want 4 0 0 0", state, time_left, won, ticket);
        end
        ticks(4);
        n_cmp++;
        if (state !== 3'd4) begin n_err++; $display("FAIL result_hold state=%0d want 4", state); end
        ticks(1);
        n_cmp++;
        if ({state, level} !== {3'd0, 3'd0}) begin
            n_err++; $display("FAIL result_auto_return state=%0d level=%0d want 0 0", state, level);
        end
    endtask

    task automatic test_win_saturate();
        do_reset();
        coins(19);
        n_cmp++;
        if (money !== 7'd95) begin n_err++; $display("FAIL coins_95 money=%0d want 95", money); end
        coins(1);
        n_cmp++;
        if (money !== 7'd99) begin n_err++; $display("FAIL coin_saturate money=%0d want 99", money); end
        key(KEY_ENTER); key(KEY_3); key(KEY_ENTER);
        n_cmp++;
        if ({state, level, money} !== {3'd3, 3'd3, 7'd89}) begin
            n_err++; $display("FAIL play_89 state=%0d level=%0d money=%0d want 3 3 89", state, level, money);
        end
        cyc(1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if ({state, won, money} !== {3'd4, 1'b1, 7'd99}) begin
            n_err++; $display("FAIL win_saturate state=%0d won=%0d money=%0d want 4 1 99", state, won, money);
        end
        key(KEY_ENTER);
        n_cmp++;
        if ({state, won} !== {3'd0, 1'b0}) begin
            n_err++; $display("FAIL win_return state=%0d won=%0d want 0 0", state, won);
        end
        key(KEY_ENTER); key(KEY_1); key(KEY_ENTER);
        cyc(1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if ({state, won, money} !== {3'd4, 1'b1, 7'd99}) begin
            n_err++; $display("FAIL win_coin_saturate state=%0d won=%0d money=%0d want 4 1 99", state, won, money);
        end
        key(KEY_ENTER);
    endtask

    task automatic test_priority();
        do_reset();
        coins(2);
        key(KEY_ENTER); key(KEY_1); key(KEY_ENTER);
        ticks(59);
        cyc(1'b1, KEY_ESC, 1'b0, 1'b1, 1'b1, 1'b1);
        n_cmp++;
        if ({state, won, money} !== {3'd4, 1'b1, 7'd20}) begin
            n_err++; $display("FAIL done_over_esc_timeout state=%0d won=%0d money=%0d want 4 1 20", state, won, money);
        end
        key(KEY_ENTER);
        coins(2);
        key(KEY_ENTER); key(KEY_2); key(KEY_ENTER);
        key(KEY_1);
        n_cmp++;
        if ({state, level, money} !== {3'd3, 3'd2, 7'd20}) begin
            n_err++; $display("FAIL play_ignores_keys state=%0d level=%0d money=%0d want 3 2 20", state, level, money);
        end
        key(KEY_ESC);
        n_cmp++;
        if ({state, won, money} !== {3'd4, 1'b0, 7'd20}) begin
            n_err++; $display("FAIL esc_only state=%0d won=%0d money=%0d want 4 0 20", state, won, money);
        end
        key(KEY_ENTER);
    endtask

    task automatic test_help_and_async_reset();
        key(KEY_ENTER);
        key(KEY_3);
        key(KEY_QMARK);
        n_cmp++;
        if (state !== 3'd2) begin n_err++; $display("FAIL help_enter state=%0d want 2", state); end
        key(KEY_1);
        n_cmp++;
        if (state !== 3'd1) begin n_err++; $display("FAIL help_exit state=%0d want 1", state); end
        key(KEY_ENTER);
        n_cmp++;
        if ({state, level, money, ticket} !== {3'd3, 3'd3, 7'd10, 1'b1}) begin
            n_err++; $display("FAIL help_keeps_level state=%0d level=%0d money=%0d ticket=%0d want 3 3 10 1",
                              state, level, money, ticket);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({state, level, ticket, money, time_left, play_start, err_no_money, won} !== 23'd0) begin
            n_err++;
            $display("FAIL async_reset state=%0d level=%0d ticket=%0d money=%0d time=%0d want all 0",
                     state, level, ticket, money, time_left);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start_game();
        test_no_money();
        test_timeout();
        test_win_saturate();
        test_priority();
        test_help_and_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
